// File: rtl/rgb_fader_pkg.sv
// Shared widths, the green breathing-state type and the saturating duty step used by all
// three fade channels.
package rgb_fader_pkg;

  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned DUTY_MAX = 255;

  localparam logic [PWM_BITS-1:0] DutyTop = DUTY_MAX[PWM_BITS-1:0];
  localparam logic [PWM_BITS-1:0] CntLast = {PWM_BITS{1'b1}};

  typedef enum logic {
    Up,
    Down
  } breathe_state_t;

  // One fade step toward 255 (up) or 0 (down), clamped at both ends via a 9-bit intermediate.
  function automatic logic [PWM_BITS-1:0] sat_step(input logic [PWM_BITS-1:0] duty,
                                                   input logic [PWM_BITS-1:0] step,
                                                   input logic                up);
    logic [PWM_BITS:0] wide;
    if (up) begin
      wide = {1'b0, duty} + {1'b0, step};
      sat_step = wide[PWM_BITS] ? DutyTop : wide[PWM_BITS-1:0];
    end else begin
      wide = {1'b0, duty} - {1'b0, step};
      sat_step = wide[PWM_BITS] ? '0 : wide[PWM_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/rgb_fader_pwm_channel.sv
// One fade channel: saturating duty ramp, period-aligned shadow duty and registered PWM compare.
// The shadow only reloads at the end of a PWM period, so the output never glitches mid-period.
module pwm_channel
  import rgb_fader_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                tick_i,
  input  logic                up_i,
  output logic [PWM_BITS-1:0] duty_next_o,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] StepVal = STEP[PWM_BITS-1:0];

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    duty_d = duty_q;
    if (tick_i) begin
      duty_d = sat_step(duty_q, StepVal, up_i);
    end
  end

  // The shadow takes the pre-tick duty when a tick coincides with the reload.
  always_comb begin
    active_d = active_q;
    if (pwm_cnt_i == CntLast) begin
      active_d = duty_q;
    end
  end

  assign pwm_d = (pwm_cnt_i < active_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_q   <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign duty_next_o = duty_d;
  assign pwm_o       = pwm_q;

endmodule

// File: rtl/rgb_fader.sv
// Three-channel PWM fader: button-driven red/blue ramps and a free-running green triangle,
// all sharing one 8-bit PWM counter and one fade-tick prescaler.
module rgb_fader
  import rgb_fader_pkg::*;
#(
  parameter int unsigned FADE_DIV = 187500,
  parameter int unsigned STEP     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_red,
  input  logic btn_blue,
  output logic pwm_red,
  output logic pwm_green,
  output logic pwm_blue
);

  localparam int unsigned DivW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FADE_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic                tick;
  breathe_state_t      breathe_q;

  logic [2:0]          ch_up;
  logic [2:0]          ch_pwm;
  logic [PWM_BITS-1:0] duty_next [3];

  assign tick      = (div_cnt_q == DivLast);
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Green reverses on the tick that lands its duty on an end stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      breathe_q <= Up;
    end else if (tick) begin
      unique case (breathe_q)
        Up:   if (duty_next[1] == DutyTop) breathe_q <= Down;
        Down: if (duty_next[1] == '0)      breathe_q <= Up;
      endcase
    end
  end

  // Channel order: 0 red, 1 green, 2 blue.
  assign ch_up = {btn_blue, (breathe_q == Up), btn_red};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    pwm_channel #(
      .STEP(STEP)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pwm_cnt_i  (pwm_cnt_q),
      .tick_i     (tick),
      .up_i       (ch_up[i]),
      .duty_next_o(duty_next[i]),
      .pwm_o      (ch_pwm[i])
    );
  end

  assign pwm_red   = ch_pwm[0];
  assign pwm_green = ch_pwm[1];
  assign pwm_blue  = ch_pwm[2];

endmodule

// File: doc/rgb_fader.md
# rgb_fader

Three-channel PWM fade generator between the debounced button stage and the SB_RGBA_DRV hard LED driver. Held button levels ramp the red and blue duty cycles up; released levels ramp them down. Green runs a continuous triangle-wave "breathing" pattern. Each channel outputs a glitch-free 8-bit PWM stream that drives one `RGBxPWM` input of the driver directly.

## Interface
- `FADE_DIV`, default 187500: clk cycles per fade tick (48 MHz / 187500 = 256 Hz).
- `STEP`, default 1: duty increment/decrement per fade tick, range 1..255.
- `clk`  in  1  system clock, 48 MHz from the global buffer.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `btn_red`  in  1  active-high "pressed" level, already synchronous to `clk`.
- `btn_blue`  in  1  active-high "pressed" level, already synchronous to `clk`.
- `pwm_red`  out  1  PWM for the red channel; reset 0.
- `pwm_green`  out  1  PWM for the green channel; reset 0.
- `pwm_blue`  out  1  PWM for the blue channel; reset 0.

## Operation
- Reset state: all outputs 0; `pwm_cnt`, `div_cnt`, every duty and every shadow duty set to 0; green FSM in UP.
- `pwm_cnt`: shared 8-bit free-running counter, +1 every clk, wraps 255→0. PWM period is 256 clk.
- Shadow load: when `pwm_cnt`==255, each channel's `active_duty` is loaded from its `duty`. Duty changes therefore take effect only from the next period that starts at `pwm_cnt`==0. No mid-period glitches.
- Compare: `pwm_x` is registered as (`pwm_cnt` < `active_duty_x`). Duty 0 keeps the output low. Duty 255 gives 255 high cycles out of 256.
- Prescaler: `div_cnt` counts 0..FADE_DIV-1 and wraps. `tick` is a one-cycle pulse in the cycle where `div_cnt`==FADE_DIV-1.
- Red and blue, on `tick` only:
  - If the button is 1: duty ← min(duty+STEP, 255).
  - If the button is 0: duty ← max(duty−STEP, 0).
  - Button levels between ticks are ignored.
- Green FSM, updated on `tick` only:
  - UP: duty ← min(duty+STEP, 255). If the new value is 255, go to DOWN.
  - DOWN: duty ← max(duty−STEP, 0). If the new value is 0, go to UP.
- Arithmetic: saturating adds and subtracts use a 9-bit intermediate. Duties never wrap.
- Simultaneous `tick` and shadow load (`pwm_cnt`==255) in the same cycle: the shadow loads the pre-tick duty. The new duty lands one period later.
- `rst_n` asserted mid-operation: all state clears immediately, with no dependence on a clock edge. After deassertion, the first `tick` occurs FADE_DIV clk later.

## Timing
- `pwm_x` lags the comparison by 1 clk. In steady state, `pwm_x` is high for the clk cycles following `pwm_cnt` values 0..active_duty−1.
- Latency from a button change to a visible duty change:
  - at most FADE_DIV clk to the next tick,
  - plus at most 256 clk to the next shadow load,
  - plus 1 clk for the output register.
- Full ramp 0→255 with STEP=1 takes 255 ticks (≈1 s at the defaults).
- Green breathing period is 510 ticks with STEP=1.
- The first rising edge of `pwm_x` after reset cannot occur before clk 257: shadows are 0 until the first load.

## Structure
- Package `rgb_fader_pkg` holds:
  - `PWM_BITS` = 8
  - `DUTY_MAX` = 255
  - the green FSM enum `breathe_state_t` {UP, DOWN}
- Sub-module `pwm_channel` is instantiated three times. Per instance it contains:
  - the shadow register,
  - the compare and output register,
  - the saturating step logic.
- Inputs to `pwm_channel`: shared `pwm_cnt`, `tick`, and a direction bit.
- The top level holds `pwm_cnt`, the prescaler and the green FSM. The green FSM drives green's direction bit.

## Test plan
Benches use FADE_DIV=4 and STEP=1 unless stated.
- Reset: hold `rst_n`=0 with buttons high → all `pwm_x`=0. Release → all outputs stay 0 through clk 256.
- Red ramp: `btn_red`=1 for 10 ticks, then check the next full period → `pwm_red` high for exactly 10 of 256 cycles. `pwm_blue` stays high for 0 cycles.
- Saturation: STEP=100, `btn_blue`=1 → duty sequence 100, 200, 255, 255. Release → 155, 55, 0, 0, with no wrap.
- Green reversal: STEP=51 → green duty 51, 102, 153, 204, 255, then 204 (FSM in DOWN), …, 0, then 51 (FSM back in UP).
- Glitch-free update: force a tick when `pwm_cnt`=100 mid-period → high-time of the current period is unchanged. The new duty appears from the next `pwm_cnt`=0.
- Async reset mid-ramp: assert `rst_n`=0 between clk edges while red duty is 40 → `pwm_red` is 0 before the next edge, and duty restarts from 0 after release.
